ysyx_24080014_wbu_arb: RTL and testbench

YSYX_24080014_WBU_ARB -- requirements
Module: ysyx_24080014_wbu_arb

---
 rtl/ysyx_24080014_pkg.sv | 13 +
 rtl/ysyx_24080014_wb_prio.sv | 66 ++++++
 rtl/ysyx_24080014_wbu_arb.sv | 108 ++++++++++
 tb/tb_ysyx_24080014_wbu_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_pkg.sv
// ysyx_24080014_pkg
// Shared definitions for the write-back arbiter slice.
//   - DATA_W_DEF / ADDR_W_DEF : default write-data and register-index widths
//   - WB_SRC_EXU / WB_SRC_LSU : encoding of the wb_src output
package ysyx_24080014_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic WB_SRC_EXU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24080014_wb_prio.sv
// ysyx_24080014_wb_prio
// Combinational grant between the EXU and LSU write-back requests.
// LSU (older instruction) wins by default. When the macro
// YSYX_24080014_WBU_STARVE_EN is defined, a 4-bit counter tracks consecutive
// EXU losses and forces an EXU grant once it reaches STARVE_MAX.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   exu_valid, lsu_valid   : request lines of the two sources
//   exu_grant, lsu_grant   : one-hot (or zero) grant, never high without valid
module ysyx_24080014_wb_prio
  import ysyx_24080014_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic exu_valid,
  input  logic lsu_valid,
  output logic exu_grant,
  output logic lsu_grant
);

`ifdef YSYX_24080014_WBU_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       force_exu_s;

  // Counter saturates at the limit, so >= and == are equivalent here.
  assign force_exu_s = (starve_cnt_q >= STARVE_LIM);

  // Grant selection and starvation counter next-state.
  always_comb begin
    lsu_grant = lsu_valid & ~(force_exu_s & exu_valid);
    exu_grant = exu_valid & (~lsu_valid | force_exu_s);
    if (!exu_valid || exu_grant) begin
      starve_cnt_d = 4'd0;
    end else if (lsu_grant && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Clock and reset only feed the optional counter.
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ rst_n;

  // Fixed LSU-over-EXU priority.
  always_comb begin
    lsu_grant = lsu_valid;
    exu_grant = exu_valid & ~lsu_valid;
  end
`endif

endmodule

// File: rtl/ysyx_24080014_wbu_arb.sv
// ysyx_24080014_wbu_arb
// Write-back arbiter: merges EXU results and LSU load data into a single
// registered register-file write port. LSU has priority; the optional
// starvation guard is enabled by the macro YSYX_24080014_WBU_STARVE_EN.
// Ports:
//   clk, rst_n                                : clock, async active-low reset
//   exu_valid/exu_ready/exu_rd/exu_data       : EXU result handshake + payload
//   lsu_valid/lsu_ready/lsu_rd/lsu_data       : LSU load handshake + payload
//   rf_wen/rf_waddr/rf_wdata/wb_src           : registered RF write port
//   busy                                      : any request pending or write in flight
module ysyx_24080014_wbu_arb
  import ysyx_24080014_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_src,
  output logic              busy
);

  logic exu_grant_s;
  logic lsu_grant_s;

  logic              rf_wen_q,   rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              wb_src_q,   wb_src_d;

  ysyx_24080014_wb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .exu_valid (exu_valid),
    .lsu_valid (lsu_valid),
    .exu_grant (exu_grant_s),
    .lsu_grant (lsu_grant_s)
  );

  // Readies are forced low while reset is held so nothing is accepted.
  assign exu_ready = exu_grant_s & rst_n;
  assign lsu_ready = lsu_grant_s & rst_n;

  // Next RF write: x0 targets are accepted but do not disturb addr/data.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_src_d   = wb_src_q;
    if (lsu_ready) begin
      if (lsu_rd != {ADDR_W{1'b0}}) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = lsu_rd;
        rf_wdata_d = lsu_data;
        wb_src_d   = WB_SRC_LSU;
      end else begin
        rf_wen_d   = 1'b0;
      end
    end else if (exu_ready) begin
      if (exu_rd != {ADDR_W{1'b0}}) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = exu_rd;
        rf_wdata_d = exu_data;
        wb_src_d   = WB_SRC_EXU;
      end else begin
        rf_wen_d   = 1'b0;
      end
    end else begin
      rf_wen_d = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= {ADDR_W{1'b0}};
      rf_wdata_q <= {DATA_W{1'b0}};
      wb_src_q   <= WB_SRC_EXU;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_src   = wb_src_q;
  assign busy     = exu_valid | lsu_valid | rf_wen_q;

endmodule

// File: tb/tb_ysyx_24080014_wbu_arb.sv
module tb_ysyx_24080014_wbu_arb;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_src;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_24080014_wbu_arb #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_src    (wb_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 32'h0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
    step();
    step();
    checks++; if (exu_ready !== 1'b0) begin errors++; $display("FAIL reset_exu_ready got=%b exp=0", exu_ready); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got=%b exp=0", lsu_ready); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    checks++; if (wb_src !== 1'b0) begin errors++; $display("FAIL reset_wb_src got=%b exp=0", wb_src); end
    idle_inputs();
    rst_n = 1'b1;
    step();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_release_wen got=%b exp=0", rf_wen); end
  endtask

  task automatic test_exu_only();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL exu_only_ready got=%b exp=1", exu_ready); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL exu_only_lsu_ready got=%b exp=0", lsu_ready); end
    step();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL exu_only_wen got=%b exp=1", rf_wen); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL exu_only_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL exu_only_wdata got=%h exp=1234", rf_wdata); end
    checks++; if (wb_src !== 1'b0) begin errors++; $display("FAIL exu_only_src got=%b exp=0", wb_src); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exu_only_busy got=%b exp=1", busy); end
    step();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL exu_only_idle_wen got=%b exp=0", rf_wen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exu_only_idle_busy got=%b exp=0", busy); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL exu_only_hold_wdata got=%h exp=1234", rf_wdata); end
  endtask

  task automatic test_collision();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAAAA;
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h5555;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL coll_lsu_ready got=%b exp=1", lsu_ready); end
    checks++; if (exu_ready !== 1'b0) begin errors++; $display("FAIL coll_exu_ready got=%b exp=0", exu_ready); end
    step();
    lsu_valid = 1'b0;
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL coll_lsu_wen got=%b exp=1", rf_wen); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL coll_lsu_waddr got=%0d exp=3", rf_waddr); end
    checks++; if (rf_wdata !== 32'hAAAA) begin errors++; $display("FAIL coll_lsu_wdata got=%h exp=aaaa", rf_wdata); end
    checks++; if (wb_src !== 1'b1) begin errors++; $display("FAIL coll_lsu_src got=%b exp=1", wb_src); end
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL coll_exu_ready2 got=%b exp=1", exu_ready); end
    step();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL coll_exu_wen got=%b exp=1", rf_wen); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL coll_exu_waddr got=%0d exp=3", rf_waddr); end
    checks++; if (rf_wdata !== 32'h5555) begin errors++; $display("FAIL coll_exu_wdata got=%h exp=5555", rf_wdata); end
    checks++; if (wb_src !== 1'b0) begin errors++; $display("FAIL coll_exu_src got=%b exp=0", wb_src); end
    step();
  endtask

  task automatic test_x0_write();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", lsu_ready); end
    step();
    idle_inputs();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got=%b exp=0", rf_wen); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL x0_hold_waddr got=%0d exp=3", rf_waddr); end
    checks++; if (rf_wdata !== 32'h5555) begin errors++; $display("FAIL x0_hold_wdata got=%h exp=5555", rf_wdata); end
    step();
  endtask

  task automatic test_back_to_back();
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL b2b_lsu_ready got=%b exp=1", lsu_ready); end
    step();
    lsu_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 32'h22;
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL b2b_exu_ready got=%b exp=1", exu_ready); end
    checks++; if ({rf_wen, rf_waddr, rf_wdata, wb_src} !== {1'b1, 5'd1, 32'h11, 1'b1})
      begin errors++; $display("FAIL b2b_first got=%b/%0d/%h/%b exp=1/1/11/1", rf_wen, rf_waddr, rf_wdata, wb_src); end
    step();
    idle_inputs();
    checks++; if ({rf_wen, rf_waddr, rf_wdata, wb_src} !== {1'b1, 5'd2, 32'h22, 1'b0})
      begin errors++; $display("FAIL b2b_second got=%b/%0d/%h/%b exp=1/2/22/0", rf_wen, rf_waddr, rf_wdata, wb_src); end
    step();
  endtask

  task automatic test_starvation();
    logic [5:0] exp_exu;
`ifdef YSYX_24080014_WBU_STARVE_EN
    exp_exu = 6'b010000;
`else
    exp_exu = 6'b000000;
`endif
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h66;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (exu_ready !== exp_exu[i]) begin errors++; $display("FAIL starve_exu_ready cycle=%0d got=%b exp=%b", i, exu_ready, exp_exu[i]); end
      checks++; if (lsu_ready !== ~exp_exu[i]) begin errors++; $display("FAIL starve_lsu_ready cycle=%0d got=%b exp=%b", i, lsu_ready, ~exp_exu[i]); end
      step();
      checks++; if (wb_src !== ~exp_exu[i]) begin errors++; $display("FAIL starve_wb_src cycle=%0d got=%b exp=%b", i, wb_src, ~exp_exu[i]); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h7777;
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_pre got=%b exp=1", exu_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (exu_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_rst got=%b exp=0", exu_ready); end
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL rmid_async_wdata got=%h exp=0", rf_wdata); end
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
    checks++; if ({rf_wen, rf_waddr, rf_wdata, wb_src} !== {1'b0, 5'd0, 32'h0, 1'b0})
      begin errors++; $display("FAIL rmid_after got=%b/%0d/%h/%b exp=0/0/0/0", rf_wen, rf_waddr, rf_wdata, wb_src); end
    step();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse got=%b exp=0", rf_wen); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_exu_only();
    test_collision();
    test_x0_write();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
